// File: rtl/denorm_shift.sv
// denorm_shift: sequential inverse of the fixed-point normalizer.
// Restores scale by left-shifting a normalized mantissa one bit per cycle,
// saturating to all-ones when a shift would push a set bit out of the top.
module denorm_shift #(
  parameter int WIDTH     = 16,
  parameter int SHW       = 5,
  parameter int MAX_SHIFT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_d,
  input  logic [SHW-1:0]   in_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_sat,
  output logic             out_clip,
  output logic             busy
);

  localparam logic [SHW-1:0] MAXS = SHW'(MAX_SHIFT);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [SHW-1:0]   cnt, cnt_n;
  logic             sat, sat_n;
  logic             clip, clip_n;

  // Next-state, accept and shift/saturate datapath
  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    sat_n   = sat;
    clip_n  = clip;
    case (state)
      IDLE: begin
        if (in_valid) begin
          acc_n = in_d;
          sat_n = 1'b0;
          if (in_i > MAXS) begin
            cnt_n  = MAXS;
            clip_n = 1'b1;
          end else begin
            cnt_n  = in_i;
            clip_n = 1'b0;
          end
          state_n = (cnt_n == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (acc[WIDTH-1]) begin
          // Next shift would lose a set bit: saturate and drop remaining count
          acc_n   = '1;
          sat_n   = 1'b1;
          state_n = DONE;
        end else begin
          acc_n = {acc[WIDTH-2:0], 1'b0};
          cnt_n = cnt - 1'b1;
          if (cnt == SHW'(1)) state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
      clip  <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      sat   <= sat_n;
      clip  <= clip_n;
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign out_y     = acc;
  assign out_sat   = sat;
  assign out_clip  = clip;

endmodule

// File: tb/tb_denorm_shift.sv
// Directed-vector bench for denorm_shift.
module tb_denorm_shift;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_d;
  logic [4:0]  in_i;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_y;
  logic        out_sat;
  logic        out_clip;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  denorm_shift #(.WIDTH(16), .SHW(5), .MAX_SHIFT(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d), .in_i(in_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_sat(out_sat), .out_clip(out_clip), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [4:0]  i;
    logic [15:0] y;
    logic        sat;
    logic        clip;
    int          lat;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Accept one operand, wait for out_valid (bounded), return result and latency.
  // out_ready is held high so the handshake follows the first valid cycle.
  task automatic run_op(input logic [15:0] d, input logic [4:0] i,
                        output logic [15:0] y, output logic s, output logic c,
                        output int lat);
    @(posedge clk); #1;
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_d = d; in_i = i;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_d = 16'($urandom); in_i = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
    y = out_y; s = out_sat; c = out_clip;
    @(posedge clk); #1;
    chk("in_ready_after_hs", in_ready, 1);
    chk("out_valid_after_hs", out_valid, 0);
  endtask

  initial begin
    logic [15:0] y, x, dn, ex;
    logic        s, c;
    int          lat;
    logic [4:0]  sh;

    tbl[0] = '{16'h00C0, 5'd3,  16'h0600, 1'b0, 1'b0, 4};
    tbl[1] = '{16'h00FF, 5'd8,  16'hFF00, 1'b0, 1'b0, 9};
    tbl[2] = '{16'h00A5, 5'd0,  16'h00A5, 1'b0, 1'b0, 1};
    tbl[3] = '{16'h00C0, 5'd9,  16'hC000, 1'b0, 1'b1, 9};
    tbl[4] = '{16'h8001, 5'd1,  16'hFFFF, 1'b1, 1'b0, 2};
    tbl[5] = '{16'h4000, 5'd4,  16'hFFFF, 1'b1, 1'b0, 3};
    tbl[6] = '{16'h0091, 5'd5,  16'h1220, 1'b0, 1'b0, 6};
    tbl[7] = '{16'h0001, 5'd31, 16'h0100, 1'b0, 1'b1, 9};
    tbl[8] = '{16'h8000, 5'd0,  16'h8000, 1'b0, 1'b0, 1};
    tbl[9] = '{16'hC000, 5'd31, 16'hFFFF, 1'b1, 1'b1, 2};

    // Reset with a simultaneous in_valid: reset wins
    rst = 1'b1; in_valid = 1'b1; in_d = 16'h1234; in_i = 5'd3; out_ready = 1'b1;
    #1;
    chk("in_ready_in_rst", in_ready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_flags", {out_sat, out_clip}, 0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("in_ready_after_rst", in_ready, 1);

    // Table vectors
    for (int k = 0; k < 10; k++) begin
      run_op(tbl[k].d, tbl[k].i, y, s, c, lat);
      chk($sformatf("v%0d_y", k), y, tbl[k].y);
      chk($sformatf("v%0d_sat", k), s, tbl[k].sat);
      chk($sformatf("v%0d_clip", k), c, tbl[k].clip);
      chk($sformatf("v%0d_lat", k), lat, tbl[k].lat);
    end

    // Backpressure: hold DONE for 5 cycles
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_d = 16'h0003; in_i = 5'd2;
    @(posedge clk); #1;
    in_valid = 1'b0; in_d = 16'hFFFF; in_i = 5'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_y", out_y, 16'h000C);
      chk("bp_flags", {out_sat, out_clip}, 0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_busy", busy, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);

    // Reset during SHIFT after two steps
    @(posedge clk); #1;
    in_valid = 1'b1; in_d = 16'h0001; in_i = 5'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy_before_rst", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_y", out_y, 0);
    for (int k = 0; k < 10; k++) begin
      if (out_valid || busy) chk("mid_rst_stale", {out_valid, busy}, 0);
      @(posedge clk); #1;
    end
    chk("mid_rst_quiet", {out_valid, busy}, 0);

    // Round trip through a normalizer model
    for (int k = 0; k < 20; k++) begin
      x = 16'($urandom);
      sh = 0;
      while ((x >> sh) >= 16'd256 && sh < 5'd8) sh++;
      dn = x >> sh;
      ex = (x >> sh) << sh;
      run_op(dn, sh, y, s, c, lat);
      chk($sformatf("rt%0d_y x=%0h", k, x), y, ex);
      chk($sformatf("rt%0d_sat", k), s, 0);
      chk($sformatf("rt%0d_lat", k), lat, int'(sh) + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
